// File: rtl/control_fsm.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback sequencing for the datapath.
// Define CTRL_FSM_CARRY_FLAG_EN to add the carry flag and the bcy/bncy branches.
module control_fsm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        ALUzero,
    input  logic        MSB,
    input  logic        ALUc_out,
    output logic        AddrSrcBSel,
    output logic [1:0]  PrimaryOutputSel,
    output logic        ShifterInputSel,
    output logic        ShifterEnblALU,
    output logic [1:0]  ShiftTypeALU,
    output logic        shamt_src,
    output logic        alu_b_imm,
    output logic        ir_we,
    output logic        pc_we,
    output logic        mem_re,
    output logic        mem_we,
    output logic        reg_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  wb_sel,
    output logic        carry_flag,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd1;
    localparam logic [5:0] OP_COMPI = 6'd2;
    localparam logic [5:0] OP_LW    = 6'd3;
    localparam logic [5:0] OP_SW    = 6'd4;
    localparam logic [5:0] OP_B     = 6'd5;
    localparam logic [5:0] OP_BR    = 6'd6;
    localparam logic [5:0] OP_BZ    = 6'd7;
    localparam logic [5:0] OP_BNZ   = 6'd8;
    localparam logic [5:0] OP_BLTZ  = 6'd9;
    localparam logic [5:0] OP_BCY   = 6'd10;
    localparam logic [5:0] OP_BNCY  = 6'd11;
    localparam logic [5:0] OP_BL    = 6'd12;

    state_t     state_q, state_d;
    logic [5:0] op;
    logic [4:0] funct;
    logic       instr_legal;
    logic       unused_instr;

    assign op           = instr[31:26];
    assign funct        = instr[4:0];
    assign unused_instr = ^instr[25:5];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Opcode 63 (halt) and every unlisted op/funct fall through to illegal.
    always_comb begin
        instr_legal = 1'b0;
        case (op)
            OP_RTYPE: instr_legal = (funct <= 5'd10);
            OP_ADDI, OP_COMPI, OP_LW, OP_SW, OP_B, OP_BR,
            OP_BZ, OP_BNZ, OP_BLTZ, OP_BL: instr_legal = 1'b1;
`ifdef CTRL_FSM_CARRY_FLAG_EN
            OP_BCY, OP_BNCY: instr_legal = 1'b1;
`endif
            default: instr_legal = 1'b0;
        endcase
    end

`ifdef CTRL_FSM_CARRY_FLAG_EN
    logic carry_q, carry_d, carry_load;

    assign carry_load = rst_n && (state_q == S_EXEC) &&
                        (((op == OP_RTYPE) && (funct <= 5'd1)) ||
                         (op == OP_ADDI) || (op == OP_COMPI));
    assign carry_d    = carry_load ? ALUc_out : carry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) carry_q <= 1'b0;
        else        carry_q <= carry_d;
    end
    assign carry_flag = carry_q;
`else
    logic unused_carry;
    assign unused_carry = ALUc_out;
    assign carry_flag   = 1'b0;
`endif

    // Memory handshake: mem_re/mem_we stay high while waiting; the cycle in
    // which mem_ready is seen high completes the access and advances the FSM.
    always_comb begin
        state_d          = state_q;
        AddrSrcBSel      = 1'b0;
        PrimaryOutputSel = 2'b00;
        ShifterEnblALU   = 1'b0;
        ShiftTypeALU     = 2'b00;
        shamt_src        = 1'b0;
        alu_b_imm        = 1'b0;
        ir_we            = 1'b0;
        pc_we            = 1'b0;
        mem_re           = 1'b0;
        mem_we           = 1'b0;
        reg_we           = 1'b0;
        pc_src           = 2'b00;
        wb_sel           = 2'b00;
        halted           = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_re = 1'b1;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: state_d = instr_legal ? S_EXEC : S_HALT;
                S_EXEC: begin
                    state_d = S_FETCH;
                    case (op)
                        OP_RTYPE: begin
                            state_d = S_WB;
                            case (funct)
                                5'd0: PrimaryOutputSel = 2'b01;
                                5'd1: begin
                                    PrimaryOutputSel = 2'b01;
                                    AddrSrcBSel      = 1'b1;
                                end
                                5'd2: PrimaryOutputSel = 2'b11;
                                5'd3: PrimaryOutputSel = 2'b10;
                                5'd5, 5'd8: ShifterEnblALU = 1'b1;
                                5'd6, 5'd9: begin
                                    ShifterEnblALU = 1'b1;
                                    ShiftTypeALU   = 2'b01;
                                end
                                5'd7, 5'd10: begin
                                    ShifterEnblALU = 1'b1;
                                    ShiftTypeALU   = 2'b10;
                                end
                                default: ;
                            endcase
                            shamt_src = (funct >= 5'd8) && (funct <= 5'd10);
                        end
                        OP_ADDI, OP_COMPI: begin
                            PrimaryOutputSel = 2'b01;
                            AddrSrcBSel      = (op == OP_COMPI);
                            alu_b_imm        = 1'b1;
                            state_d          = S_WB;
                        end
                        OP_LW, OP_SW: begin
                            PrimaryOutputSel = 2'b01;
                            alu_b_imm        = 1'b1;
                            state_d          = S_MEM;
                        end
                        OP_B: begin
                            pc_src = 2'b01;
                            pc_we  = 1'b1;
                        end
                        OP_BR: begin
                            pc_src = 2'b10;
                            pc_we  = 1'b1;
                        end
                        OP_BZ: begin
                            pc_src = 2'b01;
                            pc_we  = ALUzero;
                        end
                        OP_BNZ: begin
                            pc_src = 2'b01;
                            pc_we  = !ALUzero;
                        end
                        OP_BLTZ: begin
                            pc_src = 2'b01;
                            pc_we  = MSB;
                        end
`ifdef CTRL_FSM_CARRY_FLAG_EN
                        OP_BCY: begin
                            pc_src = 2'b01;
                            pc_we  = carry_q;
                        end
                        OP_BNCY: begin
                            pc_src = 2'b01;
                            pc_we  = !carry_q;
                        end
`endif
                        // Link write to r31 happens alongside the jump.
                        OP_BL: begin
                            pc_src = 2'b01;
                            pc_we  = 1'b1;
                            reg_we = 1'b1;
                            wb_sel = 2'b10;
                        end
                        default: state_d = S_HALT;
                    endcase
                end
                S_MEM: begin
                    mem_re = (op == OP_LW);
                    mem_we = (op != OP_LW);
                    if (mem_ready) state_d = (op == OP_LW) ? S_WB : S_FETCH;
                end
                S_WB: begin
                    reg_we  = 1'b1;
                    wb_sel  = (op == OP_LW) ? 2'b01 : 2'b00;
                    state_d = S_FETCH;
                end
                S_HALT: halted = 1'b1;
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign ShifterInputSel = ShifterEnblALU;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: reset, ALU/shift decode, memory waits, branches, halt, carry flag.
module tb_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        mem_ready, ALUzero, MSB, ALUc_out;
    logic        AddrSrcBSel, ShifterInputSel, ShifterEnblALU, shamt_src, alu_b_imm;
    logic [1:0]  PrimaryOutputSel, ShiftTypeALU, pc_src, wb_sel;
    logic        ir_we, pc_we, mem_re, mem_we, reg_we, carry_flag, halted;

    int checks = 0;
    int errors = 0;

    logic [4:0]  strb;
    logic [8:0]  exec_v;
    logic [19:0] all_o;
    assign strb   = {ir_we, pc_we, mem_re, mem_we, reg_we};
    assign exec_v = {AddrSrcBSel, PrimaryOutputSel, ShifterEnblALU, ShifterInputSel,
                     ShiftTypeALU, shamt_src, alu_b_imm};
    assign all_o  = {exec_v, strb, pc_src, wb_sel, carry_flag, halted};

    control_fsm dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
        .ALUzero(ALUzero), .MSB(MSB), .ALUc_out(ALUc_out),
        .AddrSrcBSel(AddrSrcBSel), .PrimaryOutputSel(PrimaryOutputSel),
        .ShifterInputSel(ShifterInputSel), .ShifterEnblALU(ShifterEnblALU),
        .ShiftTypeALU(ShiftTypeALU), .shamt_src(shamt_src), .alu_b_imm(alu_b_imm),
        .ir_we(ir_we), .pc_we(pc_we), .mem_re(mem_re), .mem_we(mem_we), .reg_we(reg_we),
        .pc_src(pc_src), .wb_sel(wb_sel), .carry_flag(carry_flag), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] funct);
        return {op, 21'h12345, funct};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; mem_ready = 1'b0; instr = 32'h0;
        ALUzero = 1'b0; MSB = 1'b0; ALUc_out = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // From FETCH: complete the fetch and present the new IR contents in DECODE.
    task automatic fetch_to_decode(input logic [31:0] v);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        instr = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; instr = mk(6'd0, 5'd0);
        ALUzero = 1'b0; MSB = 1'b0; ALUc_out = 1'b1;
        #3;
        checks++; if (all_o !== 20'h0) begin errors++; $display("FAIL reset_outputs got %h exp %h", all_o, 20'h0); end
        tick();
        tick();
        checks++; if (all_o !== 20'h0) begin errors++; $display("FAIL reset_hold got %h exp %h", all_o, 20'h0); end
        mem_ready = 1'b0; ALUc_out = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++; if ({strb, carry_flag, halted} !== 7'b0010000) begin errors++; $display("FAIL reset_release_fetch got %b exp %b", {strb, carry_flag, halted}, 7'b0010000); end
    endtask

    task automatic test_add();
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b0;
            #1;
            checks++; if (strb !== 5'b00100) begin errors++; $display("FAIL add_fetch_wait%0d got %b exp %b", i, strb, 5'b00100); end
            tick();
        end
        mem_ready = 1'b1;
        #1;
        checks++; if ({strb, pc_src} !== 7'b1110000) begin errors++; $display("FAIL add_fetch_done got %b exp %b", {strb, pc_src}, 7'b1110000); end
        tick();
        mem_ready = 1'b1; instr = mk(6'd0, 5'd0);
        #1;
        checks++; if (strb !== 5'b00000) begin errors++; $display("FAIL add_decode_ignores_ready got %b exp %b", strb, 5'b00000); end
        tick();
        mem_ready = 1'b0;
        #1;
        checks++; if ({exec_v, strb} !== {9'b001000000, 5'b00000}) begin errors++; $display("FAIL add_exec got %b exp %b", {exec_v, strb}, {9'b001000000, 5'b00000}); end
        tick();
        #1;
        checks++; if ({strb, wb_sel} !== 7'b0000100) begin errors++; $display("FAIL add_wb got %b exp %b", {strb, wb_sel}, 7'b0000100); end
        tick();
        #1;
        checks++; if (strb !== 5'b00100) begin errors++; $display("FAIL add_back_to_fetch got %b exp %b", strb, 5'b00100); end
    endtask

    logic [31:0] alu_instr [13];
    logic [8:0]  alu_exp   [13];

    task automatic test_alu_shift();
        for (int f = 0; f < 11; f++) alu_instr[f] = mk(6'd0, 5'(f));
        alu_instr[11] = mk(6'd1, 5'd0);
        alu_instr[12] = mk(6'd2, 5'd0);
        alu_exp[0]  = 9'b0_01_0_0_00_0_0;
        alu_exp[1]  = 9'b1_01_0_0_00_0_0;
        alu_exp[2]  = 9'b0_11_0_0_00_0_0;
        alu_exp[3]  = 9'b0_10_0_0_00_0_0;
        alu_exp[4]  = 9'b0_00_0_0_00_0_0;
        alu_exp[5]  = 9'b0_00_1_1_00_0_0;
        alu_exp[6]  = 9'b0_00_1_1_01_0_0;
        alu_exp[7]  = 9'b0_00_1_1_10_0_0;
        alu_exp[8]  = 9'b0_00_1_1_00_1_0;
        alu_exp[9]  = 9'b0_00_1_1_01_1_0;
        alu_exp[10] = 9'b0_00_1_1_10_1_0;
        alu_exp[11] = 9'b0_01_0_0_00_0_1;
        alu_exp[12] = 9'b1_01_0_0_00_0_1;
        for (int i = 0; i < 13; i++) begin
            fetch_to_decode(alu_instr[i]);
            #1;
            checks++; if ({ShifterEnblALU, ShifterInputSel} !== 2'b00) begin errors++; $display("FAIL alu%0d_decode_shift got %b exp %b", i, {ShifterEnblALU, ShifterInputSel}, 2'b00); end
            tick();
            #1;
            checks++; if ({exec_v, strb} !== {alu_exp[i], 5'b00000}) begin errors++; $display("FAIL alu%0d_exec got %b exp %b", i, {exec_v, strb}, {alu_exp[i], 5'b00000}); end
            tick();
            #1;
            checks++; if ({strb, ShifterEnblALU, ShifterInputSel} !== 7'b0000100) begin errors++; $display("FAIL alu%0d_wb got %b exp %b", i, {strb, ShifterEnblALU, ShifterInputSel}, 7'b0000100); end
            tick();
        end
    endtask

    task automatic test_mem();
        fetch_to_decode(mk(6'd3, 5'd0));
        tick();
        #1;
        checks++; if ({exec_v, strb} !== {9'b001000001, 5'b00000}) begin errors++; $display("FAIL lw_exec got %b exp %b", {exec_v, strb}, {9'b001000001, 5'b00000}); end
        tick();
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'b0;
            #1;
            checks++; if (strb !== 5'b00100) begin errors++; $display("FAIL lw_mem_wait%0d got %b exp %b", i, strb, 5'b00100); end
            tick();
        end
        mem_ready = 1'b1;
        #1;
        checks++; if (strb !== 5'b00100) begin errors++; $display("FAIL lw_mem_done got %b exp %b", strb, 5'b00100); end
        tick();
        mem_ready = 1'b0;
        #1;
        checks++; if ({strb, wb_sel} !== 7'b0000101) begin errors++; $display("FAIL lw_wb got %b exp %b", {strb, wb_sel}, 7'b0000101); end
        tick();
        #1;
        checks++; if (strb !== 5'b00100) begin errors++; $display("FAIL lw_single_reg_we got %b exp %b", strb, 5'b00100); end
        fetch_to_decode(mk(6'd4, 5'd0));
        tick();
        tick();
        #1;
        checks++; if (strb !== 5'b00010) begin errors++; $display("FAIL sw_mem_wait got %b exp %b", strb, 5'b00010); end
        tick();
        mem_ready = 1'b1;
        #1;
        checks++; if (strb !== 5'b00010) begin errors++; $display("FAIL sw_mem_done got %b exp %b", strb, 5'b00010); end
        tick();
        mem_ready = 1'b0;
        #1;
        checks++; if (strb !== 5'b00100) begin errors++; $display("FAIL sw_to_fetch got %b exp %b", strb, 5'b00100); end
    endtask

    logic [31:0] br_instr [9];
    logic        br_z     [9];
    logic        br_m     [9];
    logic [4:0]  br_strb  [9];
    logic [1:0]  br_src   [9];

    task automatic test_branches();
        br_instr[0] = mk(6'd5, 5'd0);  br_z[0] = 0; br_m[0] = 0; br_strb[0] = 5'b01000; br_src[0] = 2'b01;
        br_instr[1] = mk(6'd6, 5'd0);  br_z[1] = 0; br_m[1] = 0; br_strb[1] = 5'b01000; br_src[1] = 2'b10;
        br_instr[2] = mk(6'd7, 5'd0);  br_z[2] = 1; br_m[2] = 0; br_strb[2] = 5'b01000; br_src[2] = 2'b01;
        br_instr[3] = mk(6'd7, 5'd0);  br_z[3] = 0; br_m[3] = 1; br_strb[3] = 5'b00000; br_src[3] = 2'b01;
        br_instr[4] = mk(6'd8, 5'd0);  br_z[4] = 0; br_m[4] = 0; br_strb[4] = 5'b01000; br_src[4] = 2'b01;
        br_instr[5] = mk(6'd8, 5'd0);  br_z[5] = 1; br_m[5] = 0; br_strb[5] = 5'b00000; br_src[5] = 2'b01;
        br_instr[6] = mk(6'd9, 5'd0);  br_z[6] = 0; br_m[6] = 1; br_strb[6] = 5'b01000; br_src[6] = 2'b01;
        br_instr[7] = mk(6'd9, 5'd0);  br_z[7] = 1; br_m[7] = 0; br_strb[7] = 5'b00000; br_src[7] = 2'b01;
        br_instr[8] = mk(6'd12, 5'd0); br_z[8] = 0; br_m[8] = 0; br_strb[8] = 5'b01001; br_src[8] = 2'b01;
        for (int i = 0; i < 9; i++) begin
            fetch_to_decode(br_instr[i]);
            tick();
            ALUzero = br_z[i]; MSB = br_m[i];
            #1;
            checks++; if (strb !== br_strb[i]) begin errors++; $display("FAIL br%0d_exec_strobes got %b exp %b", i, strb, br_strb[i]); end
            if (br_strb[i][3]) begin
                checks++; if (pc_src !== br_src[i]) begin errors++; $display("FAIL br%0d_pc_src got %b exp %b", i, pc_src, br_src[i]); end
            end
            if (br_strb[i][0]) begin
                checks++; if (wb_sel !== 2'b10) begin errors++; $display("FAIL br%0d_link_wb_sel got %b exp %b", i, wb_sel, 2'b10); end
            end
            tick();
            ALUzero = 1'b0; MSB = 1'b0;
            #1;
            checks++; if (strb !== 5'b00100) begin errors++; $display("FAIL br%0d_to_fetch got %b exp %b", i, strb, 5'b00100); end
        end
    endtask

    logic [31:0] halt_instr [3];

    task automatic test_halt();
        halt_instr[0] = mk(6'd63, 5'd0);
        halt_instr[1] = mk(6'd0, 5'd11);
        halt_instr[2] = mk(6'd13, 5'd0);
        for (int i = 0; i < 3; i++) begin
            do_reset();
            fetch_to_decode(halt_instr[i]);
            tick();
            for (int c = 0; c < 3; c++) begin
                mem_ready = 1'b1;
                #1;
                checks++; if ({strb, pc_src, wb_sel, halted} !== 10'b0000000001) begin errors++; $display("FAIL halt%0d_cycle%0d got %b exp %b", i, c, {strb, pc_src, wb_sel, halted}, 10'b0000000001); end
                tick();
            end
            mem_ready = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_async_reset got %b exp %b", halted, 1'b0); end
        do_reset();
    endtask

    task automatic test_carry();
`ifdef CTRL_FSM_CARRY_FLAG_EN
        do_reset();
        fetch_to_decode(mk(6'd0, 5'd1));
        tick();
        ALUc_out = 1'b1;
        tick();
        ALUc_out = 1'b0;
        #1;
        checks++; if (carry_flag !== 1'b1) begin errors++; $display("FAIL carry_after_comp got %b exp %b", carry_flag, 1'b1); end
        tick();
        fetch_to_decode(mk(6'd0, 5'd3));
        tick();
        tick();
        #1;
        checks++; if (carry_flag !== 1'b1) begin errors++; $display("FAIL carry_kept_on_xor got %b exp %b", carry_flag, 1'b1); end
        tick();
        fetch_to_decode(mk(6'd10, 5'd0));
        tick();
        #1;
        checks++; if ({strb, pc_src} !== 7'b0100001) begin errors++; $display("FAIL bcy_taken got %b exp %b", {strb, pc_src}, 7'b0100001); end
        tick();
        fetch_to_decode(mk(6'd1, 5'd0));
        tick();
        ALUc_out = 1'b0;
        tick();
        #1;
        checks++; if (carry_flag !== 1'b0) begin errors++; $display("FAIL carry_after_addi got %b exp %b", carry_flag, 1'b0); end
        tick();
        fetch_to_decode(mk(6'd11, 5'd0));
        tick();
        #1;
        checks++; if ({strb, pc_src} !== 7'b0100001) begin errors++; $display("FAIL bncy_taken got %b exp %b", {strb, pc_src}, 7'b0100001); end
        tick();
        fetch_to_decode(mk(6'd10, 5'd0));
        tick();
        #1;
        checks++; if (strb !== 5'b00000) begin errors++; $display("FAIL bcy_not_taken got %b exp %b", strb, 5'b00000); end
        tick();
`else
        do_reset();
        fetch_to_decode(mk(6'd0, 5'd0));
        tick();
        ALUc_out = 1'b1;
        tick();
        #1;
        checks++; if (carry_flag !== 1'b0) begin errors++; $display("FAIL carry_tied_low got %b exp %b", carry_flag, 1'b0); end
        ALUc_out = 1'b0;
        tick();
        fetch_to_decode(mk(6'd10, 5'd0));
        tick();
        #1;
        checks++; if ({strb, halted} !== 6'b000001) begin errors++; $display("FAIL op10_halts got %b exp %b", {strb, halted}, 6'b000001); end
        do_reset();
        fetch_to_decode(mk(6'd11, 5'd0));
        tick();
        #1;
        checks++; if ({strb, halted} !== 6'b000001) begin errors++; $display("FAIL op11_halts got %b exp %b", {strb, halted}, 6'b000001); end
`endif
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        fetch_to_decode(mk(6'd3, 5'd0));
        tick();
        tick();
        #1;
        checks++; if (strb !== 5'b00100) begin errors++; $display("FAIL rstmem_wait got %b exp %b", strb, 5'b00100); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (all_o !== 20'h0) begin errors++; $display("FAIL rstmem_async_zero got %h exp %h", all_o, 20'h0); end
        mem_ready = 1'b1;
        tick();
        checks++; if (all_o !== 20'h0) begin errors++; $display("FAIL rstmem_hold_zero got %h exp %h", all_o, 20'h0); end
        mem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++; if (strb !== 5'b00100) begin errors++; $display("FAIL rstmem_restart_fetch got %b exp %b", strb, 5'b00100); end
        mem_ready = 1'b1;
        #1;
        checks++; if (strb !== 5'b11100) begin errors++; $display("FAIL rstmem_first_fetch got %b exp %b", strb, 5'b11100); end
        tick();
        mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_shift();
        test_mem();
        test_branches();
        test_halt();
        test_carry();
        test_reset_mid_mem();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 The block SHALL have one clock, clk, and one reset, rst_n; rst_n SHALL be asynchronous and active-low.
REQ-002 Ports (name, direction, width, meaning):
  clk  in  1  rising-edge clock
  rst_n  in  1  async active-low reset
  instr  in  32  IR contents; op=instr[31:26], funct=instr[4:0]
  mem_ready  in  1  memory completion strobe, one cycle
  ALUzero  in  1  ALU rs==0 flag
  MSB  in  1  ALU rs[31]
  ALUc_out  in  1  ALU adder carry-out
  AddrSrcBSel  out  1  1=invert B and carry-in 1 (subtract)
  PrimaryOutputSel  out  2  00 diff, 01 add, 10 xor, 11 and
  ShifterInputSel  out  1  mirrors ShifterEnblALU
  ShifterEnblALU  out  1  shift instruction active
  ShiftTypeALU  out  2  00 left logical, 01 right logical, 10 right arithmetic
  shamt_src  out  1  0=instr[10:6], 1=rt[4:0]
  alu_b_imm  out  1  ALU B from sign-extended instr[15:0]
  ir_we, pc_we, mem_re, mem_we, reg_we  out  1 each  write/access strobes
  pc_src  out  2  00 PC+1, 01 target instr[25:0], 10 rs
  wb_sel  out  2  00 ALU, 01 memory, 10 PC+1
  carry_flag  out  1  latched carry
  halted  out  1  FSM in HALT

Function
REQ-003 States: FETCH, DECODE, EXEC, MEM, WB, HALT; encoding is free; all outputs SHALL be Moore-decoded from state and instr.
REQ-004 FETCH SHALL assert mem_re and hold until mem_ready=1, then pulse ir_we and pc_we (pc_src=00) in that cycle and go to DECODE.
REQ-005 DECODE SHALL last one cycle; op=63 -> HALT; undefined op or funct -> HALT; else -> EXEC.
REQ-006 R-type (op=0) funct: 0 add, 1 comp(PrimaryOutputSel=01, AddrSrcBSel=1), 2 and, 3 xor, 4 diff, 5/6/7 shll/shrl/shra (shamt_src=0), 8/9/10 shllv/shrlv/shrav (shamt_src=1); EXEC -> WB.
REQ-007 op 1 addi, op 2 compi: alu_b_imm=1, add/comp as REQ-006; EXEC -> WB.
REQ-008 op 3 lw, op 4 sw: EXEC computes rs+imm (sel 01); -> MEM; MEM asserts mem_re (lw) or mem_we (sw) until mem_ready; lw -> WB with wb_sel=01; sw -> FETCH.
REQ-009 Branches in EXEC, then -> FETCH: op 5 b (pc_src=01), op 6 br (pc_src=10), op 7 bz if ALUzero, op 8 bnz if !ALUzero, op 9 bltz if MSB, op 12 bl (pc_src=01, reg_we with wb_sel=10 to r31 in same cycle); pc_we asserted only when taken.
REQ-010 WB SHALL pulse reg_we for exactly one cycle, then -> FETCH.
REQ-011 ShifterEnblALU=ShifterInputSel=1 only in EXEC of shift functs; 0 elsewhere.
REQ-012 mem_ready outside FETCH/MEM SHALL be ignored; no strobe SHALL be asserted in more than one state per instruction.
REQ-013 HALT SHALL be absorbing until reset; halted=1, all strobes 0.

Reset
REQ-014 On rst_n=0 the FSM SHALL enter FETCH immediately, carry_flag=0, halted=0, all strobes and selects 0, including mid-wait on mem_ready.
REQ-015 First fetch SHALL begin the first clk edge after rst_n deasserts.

Configuration
REQ-016 Macro CTRL_FSM_CARRY_FLAG_EN defined: carry_flag SHALL load ALUc_out at end of EXEC of add, comp, addi, compi; op 10 bcy branches (pc_src=01) if carry_flag=1, op 11 bncy if 0.
REQ-017 Macro undefined: carry_flag tied 0, ops 10/11 SHALL decode as undefined -> HALT.

Verification
REQ-018 Reset, mem_ready=1 after 3 cycles, instr=add (op0,funct0) -> ir_we at cycle 3, PrimaryOutputSel=01 in EXEC, reg_we one cycle in WB, back to FETCH.
REQ-019 lw with mem_ready delayed 5 cycles in MEM -> mem_re held 5 cycles, single reg_we with wb_sel=01.
REQ-020 bz with ALUzero=1 -> pc_we=1, pc_src=01; ALUzero=0 -> pc_we=0, next state FETCH.
REQ-021 shrav (funct 10) -> ShifterEnblALU=1, ShiftTypeALU=10, shamt_src=1 in EXEC only.
REQ-022 With CTRL_FSM_CARRY_FLAG_EN: comp with ALUc_out=1 then bcy -> taken; without macro: op 10 -> halted=1.
REQ-023 rst_n low during MEM wait -> outputs 0 asynchronously, restart in FETCH.
